// File: rtl/mtime_counter_if.sv
// Memory-bus bundle shared by the machine-time counter and the timer.
// The master drives address/strobes/write data; the slave returns combinational read data.
interface mtime_counter_if;
    logic [31:0] address_in;
    logic        sel_in;
    logic        read_in;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;

    modport master (
        output address_in,
        output sel_in,
        output read_in,
        output write_mask_in,
        output write_value_in,
        input  read_value_out
    );

    modport slave (
        input  address_in,
        input  sel_in,
        input  read_in,
        input  write_mask_in,
        input  write_value_in,
        output read_value_out
    );
endinterface

// File: rtl/mtime_counter.sv
// Free-running 64-bit machine-time counter with programmable prescaler, pause/clear control
// and an MTIMEL-triggered high-word shadow for tear-free 64-bit reads over the 32-bit bus.
module mtime_counter #(
    parameter int unsigned PRESCALE_RESET = 0,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_,
    mtime_counter_if.slave       bus,
    output logic [63:0]          cycle_out,
    output logic                 tick_out
);

    localparam logic [1:0] ADDR_MTIMEL   = 2'b00;
    localparam logic [1:0] ADDR_MTIMEH   = 2'b01;
    localparam logic [1:0] ADDR_PRESCALE = 2'b10;
    localparam logic [1:0] ADDR_CTRL     = 2'b11;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_CLR    = 3'd1,
        OP_CTRL   = 3'd2,
        OP_WR_LO  = 3'd3,
        OP_WR_HI  = 3'd4,
        OP_WR_PRE = 3'd5
    } bus_op_e;

    // Expand the 4-bit byte enable into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask_bits(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

    logic [63:0]               mtime_r;
    logic [31:0]               hi_shadow_r;
    logic [PRESCALE_WIDTH-1:0] prescale_r;
    logic [PRESCALE_WIDTH-1:0] prescale_cnt_r;
    logic                      en_r;
    logic                      tick_r;

    logic [63:0]               mtime_nxt_s;
    logic [31:0]               hi_shadow_nxt_s;
    logic [PRESCALE_WIDTH-1:0] prescale_nxt_s;
    logic [PRESCALE_WIDTH-1:0] prescale_cnt_nxt_s;
    logic [PRESCALE_WIDTH-1:0] cnt_base_s;
    logic                      en_nxt_s;
    logic                      tick_nxt_s;
    logic                      inc_base_s;

    logic [1:0]                addr_s;
    logic                      wr_s;
    logic                      rd_lo_s;
    logic [31:0]               wmask_s;
    bus_op_e                   op_s;
    logic [31:0]               read_value_s;
    logic                      unused_addr_s;

    assign addr_s        = bus.address_in[3:2];
    assign wr_s          = bus.sel_in & (bus.write_mask_in != 4'b0000);
    assign rd_lo_s       = bus.sel_in & bus.read_in & (addr_s == ADDR_MTIMEL);
    assign wmask_s       = byte_mask_bits(bus.write_mask_in);
    assign unused_addr_s = ^{bus.address_in[31:4], bus.address_in[1:0]};

    // Decode the bus write into a single prioritised operation.
    always_comb begin
        op_s = OP_NONE;
        if (wr_s) begin
            case (addr_s)
                ADDR_MTIMEL:   op_s = OP_WR_LO;
                ADDR_MTIMEH:   op_s = OP_WR_HI;
                ADDR_PRESCALE: op_s = OP_WR_PRE;
                ADDR_CTRL:     op_s = bus.write_mask_in[0] ? (bus.write_value_in[1] ? OP_CLR : OP_CTRL) : OP_NONE;
                default:       op_s = OP_NONE;
            endcase
        end else begin
            op_s = OP_NONE;
        end
    end

    // Prescaler: decide whether this edge is an increment edge.
    always_comb begin
        inc_base_s = 1'b0;
        cnt_base_s = prescale_cnt_r;
        if (en_r && (prescale_cnt_r == prescale_r)) begin
            inc_base_s = 1'b1;
            cnt_base_s = {PRESCALE_WIDTH{1'b0}};
        end else if (en_r) begin
            cnt_base_s = prescale_cnt_r + {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_base_s = prescale_cnt_r;
        end
    end

    // Next state: bus operations override the free-running increment.
    always_comb begin
        mtime_nxt_s        = inc_base_s ? (mtime_r + 64'd1) : mtime_r;
        prescale_cnt_nxt_s = cnt_base_s;
        tick_nxt_s         = inc_base_s;
        prescale_nxt_s     = prescale_r;
        en_nxt_s           = en_r;
        hi_shadow_nxt_s    = rd_lo_s ? mtime_r[63:32] : hi_shadow_r;
        case (op_s)
            OP_CLR: begin
                mtime_nxt_s        = 64'd0;
                prescale_cnt_nxt_s = {PRESCALE_WIDTH{1'b0}};
                tick_nxt_s         = 1'b0;
                en_nxt_s           = bus.write_value_in[0];
            end
            OP_CTRL: begin
                en_nxt_s = bus.write_value_in[0];
            end
            OP_WR_LO: begin
                mtime_nxt_s        = {mtime_r[63:32], (mtime_r[31:0] & ~wmask_s) | (bus.write_value_in & wmask_s)};
                prescale_cnt_nxt_s = {PRESCALE_WIDTH{1'b0}};
                tick_nxt_s         = 1'b0;
            end
            OP_WR_HI: begin
                mtime_nxt_s        = {(mtime_r[63:32] & ~wmask_s) | (bus.write_value_in & wmask_s), mtime_r[31:0]};
                hi_shadow_nxt_s    = (hi_shadow_r & ~wmask_s) | (bus.write_value_in & wmask_s);
                prescale_cnt_nxt_s = {PRESCALE_WIDTH{1'b0}};
                tick_nxt_s         = 1'b0;
            end
            OP_WR_PRE: begin
                prescale_nxt_s     = (prescale_r & ~wmask_s[PRESCALE_WIDTH-1:0])
                                   | (bus.write_value_in[PRESCALE_WIDTH-1:0] & wmask_s[PRESCALE_WIDTH-1:0]);
                prescale_cnt_nxt_s = {PRESCALE_WIDTH{1'b0}};
            end
            default: begin
                tick_nxt_s = inc_base_s;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            mtime_r        <= 64'd0;
            hi_shadow_r    <= 32'd0;
            prescale_r     <= PRESCALE_WIDTH'(PRESCALE_RESET);
            prescale_cnt_r <= {PRESCALE_WIDTH{1'b0}};
            en_r           <= 1'b1;
            tick_r         <= 1'b0;
        end else begin
            mtime_r        <= mtime_nxt_s;
            hi_shadow_r    <= hi_shadow_nxt_s;
            prescale_r     <= prescale_nxt_s;
            prescale_cnt_r <= prescale_cnt_nxt_s;
            en_r           <= en_nxt_s;
            tick_r         <= tick_nxt_s;
        end
    end

    // Combinational read mux; CLR and unused bits always read as zero.
    always_comb begin
        read_value_s = 32'd0;
        if (bus.sel_in) begin
            case (addr_s)
                ADDR_MTIMEL:   read_value_s = mtime_r[31:0];
                ADDR_MTIMEH:   read_value_s = hi_shadow_r;
                ADDR_PRESCALE: read_value_s = {{(32-PRESCALE_WIDTH){1'b0}}, prescale_r};
                ADDR_CTRL:     read_value_s = {31'd0, en_r};
                default:       read_value_s = 32'd0;
            endcase
        end else begin
            read_value_s = 32'd0;
        end
    end

    assign bus.read_value_out = read_value_s;
    assign cycle_out          = mtime_r;
    assign tick_out           = tick_r;

endmodule
